// File: rtl/display_mux.sv
// rtl/display_mux.sv - four-digit multiplexed 7-segment display driver with win/lose modes
// Frame-coherent shadow capture; LOSE blanks the anodes on a frame-counted blink.
module display_mux #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 100,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] minutos,
  input  logic [3:0] segundos_dez,
  input  logic [3:0] segundos_unidade,
  input  logic [3:0] decimos,
  input  logic       sinalderrota,
  input  logic       sinalvitoria,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_sync
);

  localparam int             PW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  PMAX = PW'(SCAN_DIV - 1);
  localparam logic [9:0]     BMAX = 10'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {S_RUN, S_WIN, S_LOSE} state_t;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;
  logic [9:0]    r_blink_cnt;
  logic          r_blink_on;
  state_t        r_state;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_an;
  logic          r_frame_sync;

  logic          w_tick;
  logic          w_boundary;
  logic [1:0]    w_idx_nxt;
  logic [15:0]   w_shadow_nxt;
  state_t        w_state_nxt;
  logic [9:0]    w_blink_cnt_nxt;
  logic          w_blink_on_nxt;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_raw;
  logic [3:0]    w_an_raw;

  assign w_tick       = (r_presc == PMAX);
  assign w_boundary   = w_tick && (r_idx == 2'd3);
  assign w_idx_nxt    = w_tick ? r_idx + 2'd1 : r_idx;
  assign w_shadow_nxt = (w_boundary && r_state != S_WIN)
                        ? {minutos, segundos_dez, segundos_unidade, decimos} : r_shadow;
  assign w_digit      = w_shadow_nxt[w_idx_nxt*4 +: 4];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN:   if (sinalderrota) w_state_nxt = S_LOSE;
               else if (sinalvitoria) w_state_nxt = S_WIN;
      S_WIN:   if (sinalderrota) w_state_nxt = S_LOSE;
               else if (!sinalvitoria) w_state_nxt = S_RUN;
      S_LOSE:  if (!sinalderrota) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Blink only runs while staying in LOSE; entry and any other state force phase ON.
  always_comb begin
    w_blink_cnt_nxt = r_blink_cnt;
    w_blink_on_nxt  = r_blink_on;
    if (r_state != S_LOSE || w_state_nxt != S_LOSE) begin
      w_blink_cnt_nxt = '0;
      w_blink_on_nxt  = 1'b1;
    end else if (w_boundary) begin
      if (r_blink_cnt == BMAX) begin
        w_blink_cnt_nxt = '0;
        w_blink_on_nxt  = ~r_blink_on;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + 10'd1;
      end
    end
  end

  always_comb begin
    w_seg_raw = 7'b1000000;
    case (w_digit)
      4'd0: w_seg_raw = 7'b0111111;
      4'd1: w_seg_raw = 7'b0000110;
      4'd2: w_seg_raw = 7'b1011011;
      4'd3: w_seg_raw = 7'b1001111;
      4'd4: w_seg_raw = 7'b1100110;
      4'd5: w_seg_raw = 7'b1101101;
      4'd6: w_seg_raw = 7'b1111101;
      4'd7: w_seg_raw = 7'b0000111;
      4'd8: w_seg_raw = 7'b1111111;
      4'd9: w_seg_raw = 7'b1101111;
      default: w_seg_raw = 7'b1000000;
    endcase
  end

  assign w_an_raw = w_blink_on_nxt ? (4'b0001 << w_idx_nxt) : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_blink_cnt  <= '0;
      r_blink_on   <= 1'b1;
      r_state      <= S_RUN;
      r_seg        <= {7{ACTIVE_LOW}};
      r_dp         <= ACTIVE_LOW;
      r_an         <= {4{ACTIVE_LOW}};
      r_frame_sync <= 1'b0;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + 1'b1;
      r_idx        <= w_idx_nxt;
      r_shadow     <= w_shadow_nxt;
      r_blink_cnt  <= w_blink_cnt_nxt;
      r_blink_on   <= w_blink_on_nxt;
      r_state      <= w_state_nxt;
      // Outputs are built from next-cycle index/shadow so they track the tick with one clk latency.
      r_seg        <= w_seg_raw ^ {7{ACTIVE_LOW}};
      r_dp         <= w_idx_nxt[0] ^ ACTIVE_LOW;
      r_an         <= w_an_raw ^ {4{ACTIVE_LOW}};
      r_frame_sync <= w_boundary;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_sync = r_frame_sync;

endmodule

// File: doc/display_mux.md
DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 Parameter SCAN_DIV, default 50000, meaning clk cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter BLINK_FRAMES, default 100, meaning full scan frames per blink half-period in LOSE; legal range 1..1023.
REQ-003 Parameter ACTIVE_LOW, default 1, meaning 1 drives seg, dp and an active-low and 0 drives them active-high.
REQ-004 Port clk, input, 1 bit, system clock; the block has one clock and all logic is clocked on its rising edge.
REQ-005 Port reset, input, 1 bit, synchronous active-high reset.
REQ-006 Port minutos, input, 4 bits, BCD minutes digit.
REQ-007 Port segundos_dez, input, 4 bits, BCD tens-of-seconds digit.
REQ-008 Port segundos_unidade, input, 4 bits, BCD units-of-seconds digit.
REQ-009 Port decimos, input, 4 bits, BCD tenths digit.
REQ-010 Port sinalderrota, input, 1 bit, level, defeat (time expired).
REQ-011 Port sinalvitoria, input, 1 bit, level, victory (bomb defused).
REQ-012 Port seg, output, 7 bits, segments {g,f,e,d,c,b,a}, registered.
REQ-013 Port dp, output, 1 bit, decimal point, registered.
REQ-014 Port an, output, 4 bits, one-hot digit enable: an[3]=minutos, an[2]=segundos_dez, an[1]=segundos_unidade, an[0]=decimos; registered.
REQ-015 Port frame_sync, output, 1 bit, one-cycle pulse at each frame boundary, registered.

Function
REQ-016 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick SHALL be asserted in the cycle the count equals SCAN_DIV-1.
REQ-017 Digit index SHALL advance 0->1->2->3->0 on each tick; the 3->0 wrap is a frame boundary.
REQ-018 At each frame boundary, all four input digits SHALL be captured together into a shadow register; the display SHALL show only shadow values so that no frame mixes two counter states.
REQ-019 frame_sync SHALL pulse high for exactly one cycle, in the cycle after each frame-boundary tick.
REQ-020 seg, dp and an SHALL reflect the new index in the cycle after the tick; latency is one clk.
REQ-021 The decoder SHALL map 0-9 to standard 7-segment patterns (0=abcdef, 1=bc, 7=abc, 8=all); codes 10-15 SHALL display '-' (g only).
REQ-022 dp SHALL be lit while index is 3 or 1 (display format M.SS.d) and unlit otherwise.
REQ-023 The state machine SHALL have states RUN, WIN and LOSE, and the state SHALL be evaluated every clk.
REQ-024 The transition RUN->LOSE SHALL occur when sinalderrota=1; RUN->WIN SHALL occur when sinalvitoria=1 and sinalderrota=0; if both are 1, LOSE has priority.
REQ-025 The transition WIN->RUN SHALL occur when sinalvitoria=0; WIN->LOSE SHALL occur when sinalderrota=1.
REQ-026 The transition LOSE->RUN SHALL occur when sinalderrota=0; LOSE is not left on sinalvitoria.
REQ-027 In WIN, shadow capture SHALL be suppressed (display frozen, steady); scanning continues.
REQ-028 In LOSE, shadow capture SHALL continue and a blink phase SHALL toggle every BLINK_FRAMES frame boundaries; during the off phase, an SHALL be all inactive.
REQ-029 On entry to LOSE, the blink phase SHALL be ON and the blink counter SHALL be cleared; in RUN and WIN, the phase SHALL be held ON.
REQ-030 Exactly one an bit SHALL be active at any time outside reset and the LOSE off phase.
REQ-031 Polarity SHALL be applied at the output register only; internal logic is active-high.

Reset
REQ-032 While reset=1 at a clk edge, the prescaler, index, blink counter and shadow SHALL be 0; state SHALL be RUN; blink phase SHALL be ON.
REQ-033 During reset, seg, dp and an SHALL be all inactive (all 1s when ACTIVE_LOW=1) and frame_sync SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL take effect at the next edge, overriding any tick or transition in the same cycle.
REQ-035 After release, the first tick SHALL occur SCAN_DIV cycles later, and shadow SHALL show 0 until the first frame boundary.

Verification (SCAN_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=1)
REQ-036 Release reset, inputs 4,5,9,9 -> first frame shows 0.00.0; after frame_sync, an cycles 1110,1101,1011,0111 every 4 clks; seg for 4 = 0011001 inverted per REQ-031; dp low on an[3] and an[1].
REQ-037 Change decimos mid-frame from 9 to 8 -> change not visible until the digit-0 slot following the next frame_sync.
REQ-038 Assert sinalvitoria, then change inputs -> display frozen at the pre-victory values; deassert -> updates resume at the next frame boundary.
REQ-039 Assert sinalderrota -> an is ON for 2 frames, all-1 for 2 frames, and repeats; deassert -> steady scan.
REQ-040 Assert both flags in the same cycle -> LOSE blink; input 4'hC -> seg shows '-'.
REQ-041 Pulse reset in the middle of a digit slot -> outputs inactive the next cycle, then the REQ-036 sequence restarts.
